// File: rtl/exec_stage_pkg.sv
// rtl/exec_stage_pkg.sv - shared func3 codes, FSM states and branch compare for exec_stage
package exec_stage_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic taken;
        case (f3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) < $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = (a < b);
            F3_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/exec_stage_serial_shifter.sv
// rtl/exec_stage_serial_shifter.sv - one-bit-per-cycle shifter used when BARREL_SHIFT_EN is undefined
module exec_stage_serial_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dir,
    input  logic        arith,
    input  logic [4:0]  shamt,
    input  logic [31:0] data,
    output logic        done,
    output logic [31:0] q
);

    logic [31:0] sh;
    logic [4:0]  cnt;
    logic        dir_q;
    logic        arith_q;

    // q is the value after the shift performed this cycle, so the final bit lands when done is high
    assign q    = dir_q ? {arith_q & sh[31], sh[31:1]} : {sh[30:0], 1'b0};
    assign done = (cnt == 5'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            sh      <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (start) begin
            sh      <= data;
            cnt     <= shamt;
            dir_q   <= dir;
            arith_q <= arith;
        end else if (cnt != 5'd0) begin
            sh  <= q;
            cnt <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - RV32I execute stage; BARREL_SHIFT_EN selects single-cycle shifts over the serial shifter
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic            is_store,
    input  logic            is_load,
    input  logic            is_ui,
    input  logic            add_pc,
    input  logic            is_branch,
    input  logic            is_jump,
    input  logic            is_reg,
    input  logic            is_alu,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [XLEN-1:0] branch_dest,
    input  logic [4:0]      dest,
    input  logic [2:0]      func3,
    input  logic            func7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wb_dest,
    output logic            wb_en,
    output logic            mem_load,
    output logic            mem_store,
    output logic            redirect,
    output logic [XLEN-1:0] target
);

    logic [4:0]      shamt;
    logic            accept;
    logic            idle;
    logic            start_shift;
    logic            shift_done;
    logic            redirect_q;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] nxt_result;
    logic [XLEN-1:0] nxt_target;
    logic            nxt_wb_en;
    logic            nxt_load;
    logic            nxt_store;
    logic            nxt_redirect;

    assign shamt    = operand_b[4:0];
    assign in_ready = !reset && idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign redirect = redirect_q && out_valid;

`ifdef BARREL_SHIFT_EN
    assign idle        = 1'b1;
    assign start_shift = 1'b0;
    assign shift_done  = 1'b0;
`else
    state_t      state;
    logic        is_shift;
    logic        sh_done;
    logic [31:0] sh_q;
    logic [4:0]  pend_dest;
    logic        pend_wb_en;

    assign is_shift    = is_alu && (func3 == F3_SLL || func3 == F3_SR);
    assign idle        = (state == ST_IDLE);
    assign start_shift = accept && is_shift && (shamt != 5'd0);
    assign shift_done  = (state == ST_SHIFT) && sh_done;

    exec_stage_serial_shifter u_shifter (
        .clk   (clk),
        .reset (reset),
        .start (start_shift),
        .dir   (func3[2]),
        .arith (func7),
        .shamt (shamt),
        .data  (operand_a),
        .done  (sh_done),
        .q     (sh_q)
    );
`endif

    always_comb begin
        alu_res = operand_a;
        case (func3)
            F3_ADD:  alu_res = func7 ? operand_a - operand_b : operand_a + operand_b;
            F3_SLT:  alu_res = {31'd0, $signed(operand_a) < $signed(operand_b)};
            F3_SLTU: alu_res = {31'd0, operand_a < operand_b};
            F3_XOR:  alu_res = operand_a ^ operand_b;
            F3_OR:   alu_res = operand_a | operand_b;
            F3_AND:  alu_res = operand_a & operand_b;
`ifdef BARREL_SHIFT_EN
            F3_SLL:  alu_res = operand_a << shamt;
            F3_SR:   alu_res = func7 ? $signed(operand_a) >>> shamt : operand_a >> shamt;
`endif
            // serial build: only a zero shift amount reaches here, and that yields operand_a
            default: alu_res = operand_a;
        endcase
    end

    always_comb begin
        nxt_result   = '0;
        nxt_target   = '0;
        nxt_wb_en    = 1'b0;
        nxt_load     = 1'b0;
        nxt_store    = 1'b0;
        nxt_redirect = 1'b0;
        if (is_jump) begin
            nxt_result   = pc + 32'd4;
            nxt_target   = is_reg ? ((operand_a + operand_b) & ~32'd1) : pc + operand_a;
            nxt_redirect = 1'b1;
            nxt_wb_en    = (dest != 5'd0);
        end else if (is_branch) begin
            nxt_target   = pc + branch_dest;
            nxt_redirect = branch_taken(func3, operand_a, operand_b);
        end else if (is_load || is_store) begin
            nxt_result = operand_a + operand_b;
            nxt_load   = is_load;
            nxt_store  = is_store;
            nxt_wb_en  = is_load && (dest != 5'd0);
        end else if (is_ui) begin
            nxt_result = add_pc ? pc + operand_a : operand_a;
            nxt_wb_en  = (dest != 5'd0);
        end else if (is_alu) begin
            nxt_result = alu_res;
            nxt_wb_en  = (dest != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            result     <= '0;
            wb_dest    <= '0;
            wb_en      <= 1'b0;
            mem_load   <= 1'b0;
            mem_store  <= 1'b0;
            redirect_q <= 1'b0;
            target     <= '0;
`ifndef BARREL_SHIFT_EN
            state      <= ST_IDLE;
            pend_dest  <= '0;
            pend_wb_en <= 1'b0;
`endif
        end else begin
            if (accept && !start_shift) begin
                out_valid  <= 1'b1;
                result     <= nxt_result;
                wb_dest    <= dest;
                wb_en      <= nxt_wb_en;
                mem_load   <= nxt_load;
                mem_store  <= nxt_store;
                redirect_q <= nxt_redirect;
                target     <= nxt_target;
            end
`ifndef BARREL_SHIFT_EN
            else if (shift_done) begin
                out_valid  <= 1'b1;
                result     <= sh_q;
                wb_dest    <= pend_dest;
                wb_en      <= pend_wb_en;
                mem_load   <= 1'b0;
                mem_store  <= 1'b0;
                redirect_q <= 1'b0;
                target     <= '0;
            end
`endif
            else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifndef BARREL_SHIFT_EN
            case (state)
                ST_IDLE: begin
                    if (start_shift) begin
                        state      <= ST_SHIFT;
                        pend_dest  <= dest;
                        pend_wb_en <= (dest != 5'd0);
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - table-driven bench for exec_stage plus handshake, stall and reset sequences
module tb_exec_stage;

    localparam logic [7:0] FL_ALU = 8'h01, FL_REG = 8'h02, FL_JUMP = 8'h04, FL_BR = 8'h08;
    localparam logic [7:0] FL_PC  = 8'h10, FL_UI  = 8'h20, FL_LD   = 8'h40, FL_ST = 8'h80;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] pc, operand_a, operand_b, branch_dest, result, target;
    logic        is_store, is_load, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu;
    logic [4:0]  dest, wb_dest;
    logic [2:0]  func3;
    logic        func7;
    logic        wb_en, mem_load, mem_store, redirect;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exec_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
        .is_store(is_store), .is_load(is_load), .is_ui(is_ui), .add_pc(add_pc),
        .is_branch(is_branch), .is_jump(is_jump), .is_reg(is_reg), .is_alu(is_alu),
        .operand_a(operand_a), .operand_b(operand_b), .branch_dest(branch_dest),
        .dest(dest), .func3(func3), .func7(func7), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .wb_dest(wb_dest), .wb_en(wb_en),
        .mem_load(mem_load), .mem_store(mem_store), .redirect(redirect), .target(target)
    );

    typedef struct {
        string       nm;
        logic [7:0]  fl;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc, a, b, bd;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        chk_res;
        logic        wb, ld, st, rdr;
        logic [31:0] tgt;
        logic        chk_tgt;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [7:0] fl, input logic [2:0] f3,
                                input logic f7, input logic [31:0] vpc, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] bd, input logic [4:0] rd,
                                input logic [31:0] res, input logic chk_res, input logic wb,
                                input logic ld, input logic st, input logic rdr,
                                input logic [31:0] tgt, input logic chk_tgt, input int lat);
        vec_t v;
        v.nm = nm; v.fl = fl; v.f3 = f3; v.f7 = f7; v.pc = vpc; v.a = a; v.b = b; v.bd = bd;
        v.rd = rd; v.res = res; v.chk_res = chk_res; v.wb = wb; v.ld = ld; v.st = st;
        v.rdr = rdr; v.tgt = tgt; v.chk_tgt = chk_tgt;
`ifdef BARREL_SHIFT_EN
        v.lat = 1;
`else
        v.lat = lat;
`endif
        return v;
    endfunction

    task automatic drive(input logic [7:0] fl, input logic [2:0] f3, input logic f7,
                         input logic [31:0] vpc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] bd, input logic [4:0] rd);
        {is_store, is_load, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu} = fl;
        func3 = f3; func7 = f7; pc = vpc; operand_a = a; operand_b = b;
        branch_dest = bd; dest = rd;
    endtask

    // called at a negedge; returns at the negedge where out_valid is first seen
    task automatic run_vec(input vec_t v);
        int lat;
        drive(v.fl, v.f3, v.f7, v.pc, v.a, v.b, v.bd, v.rd);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({v.nm, ".in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({v.nm, ".out_valid"}, out_valid, 1);
        check({v.nm, ".latency"}, lat, v.lat);
        if (v.chk_res) check({v.nm, ".result"}, result, v.res);
        check({v.nm, ".wb_dest"}, wb_dest, v.rd);
        check({v.nm, ".wb_en"}, wb_en, v.wb);
        check({v.nm, ".mem_load"}, mem_load, v.ld);
        check({v.nm, ".mem_store"}, mem_store, v.st);
        check({v.nm, ".redirect"}, redirect, v.rdr);
        if (v.chk_tgt) check({v.nm, ".target"}, target, v.tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        //        name      flags          f3    f7 pc         a             b             bd            rd  res           cr wb ld st rd tgt        ct lat
        vecs.push_back(mk("add",    FL_ALU|FL_REG, 3'd0, 0, 32'h0,     32'd900,      32'd2000,     32'h0,        29, 32'd2900,     1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("sub",    FL_ALU|FL_REG, 3'd0, 1, 32'h0,     32'd5,        32'd7,        32'h0,        3,  32'hFFFFFFFE, 1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("addwrap",FL_ALU,        3'd0, 0, 32'h0,     32'hFFFFFFFF, 32'd2,        32'h0,        4,  32'd1,        1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("add_x0", FL_ALU|FL_REG, 3'd0, 0, 32'h0,     32'd1,        32'd1,        32'h0,        0,  32'd2,        1, 0, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("srai",   FL_ALU,        3'd5, 1, 32'h0,     32'hFFFFF000, 32'd4,        32'h0,        5,  32'hFFFFFF00, 1, 1, 0, 0, 0, 32'h0,     0, 5));
        vecs.push_back(mk("srli31", FL_ALU,        3'd5, 0, 32'h0,     32'h80000000, 32'd31,       32'h0,        6,  32'd1,        1, 1, 0, 0, 0, 32'h0,     0, 32));
        vecs.push_back(mk("sra1",   FL_ALU|FL_REG, 3'd5, 1, 32'h0,     32'h80000000, 32'd1,        32'h0,        6,  32'hC0000000, 1, 1, 0, 0, 0, 32'h0,     0, 2));
        vecs.push_back(mk("slli0",  FL_ALU,        3'd1, 0, 32'h0,     32'd1234,     32'd0,        32'h0,        7,  32'd1234,     1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("sll_b5", FL_ALU|FL_REG, 3'd1, 0, 32'h0,     32'd3,        32'h24,       32'h0,        8,  32'h30,       1, 1, 0, 0, 0, 32'h0,     0, 5));
        vecs.push_back(mk("slt",    FL_ALU|FL_REG, 3'd2, 0, 32'h0,     32'hFFFFFFFF, 32'd1,        32'h0,        9,  32'd1,        1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("sltu",   FL_ALU|FL_REG, 3'd3, 0, 32'h0,     32'hFFFFFFFF, 32'd1,        32'h0,        9,  32'd0,        1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("xor",    FL_ALU|FL_REG, 3'd4, 0, 32'h0,     32'hF0F0,     32'hFF00,     32'h0,        10, 32'h0FF0,     1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("or",     FL_ALU|FL_REG, 3'd6, 0, 32'h0,     32'hF0F0,     32'hFF00,     32'h0,        11, 32'hFFF0,     1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("and",    FL_ALU|FL_REG, 3'd7, 0, 32'h0,     32'hF0F0,     32'hFF00,     32'h0,        12, 32'hF000,     1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("beq_t",  FL_BR,         3'd0, 0, 32'h100,   32'd7,        32'd7,        32'd2000,     0,  32'h0,        0, 0, 0, 0, 1, 32'h8D0,   1, 1));
        vecs.push_back(mk("beq_nt", FL_BR,         3'd0, 0, 32'h100,   32'd7,        32'd8,        32'd2000,     0,  32'h0,        0, 0, 0, 0, 0, 32'h8D0,   1, 1));
        vecs.push_back(mk("bne_t",  FL_BR,         3'd1, 0, 32'h100,   32'd7,        32'd8,        32'd2000,     0,  32'h0,        0, 0, 0, 0, 1, 32'h8D0,   1, 1));
        vecs.push_back(mk("blt_t",  FL_BR,         3'd4, 0, 32'h200,   32'hFFFFFFFB, 32'd3,        32'hFFFFFFF0, 0,  32'h0,        0, 0, 0, 0, 1, 32'h1F0,   1, 1));
        vecs.push_back(mk("bge_nt", FL_BR,         3'd5, 0, 32'h200,   32'hFFFFFFFB, 32'd3,        32'hFFFFFFF0, 0,  32'h0,        0, 0, 0, 0, 0, 32'h1F0,   1, 1));
        vecs.push_back(mk("bltu_nt",FL_BR,         3'd6, 0, 32'h200,   32'hFFFFFFFB, 32'd3,        32'h10,       0,  32'h0,        0, 0, 0, 0, 0, 32'h210,   1, 1));
        vecs.push_back(mk("bgeu_t", FL_BR,         3'd7, 0, 32'h200,   32'hFFFFFFFB, 32'd3,        32'h10,       0,  32'h0,        0, 0, 0, 0, 1, 32'h210,   1, 1));
        vecs.push_back(mk("b010_nt",FL_BR,         3'd2, 0, 32'h200,   32'd5,        32'd5,        32'h10,       0,  32'h0,        0, 0, 0, 0, 0, 32'h210,   1, 1));
        vecs.push_back(mk("jalr",   FL_JUMP|FL_REG,3'd0, 0, 32'h40,    32'd12345,    32'd2000,     32'h0,        2,  32'h44,       1, 1, 0, 0, 1, 32'd14344, 1, 1));
        vecs.push_back(mk("jal",    FL_JUMP,       3'd0, 0, 32'h1000,  32'h20,       32'h0,        32'h0,        1,  32'h1004,     1, 1, 0, 0, 1, 32'h1020,  1, 1));
        vecs.push_back(mk("ld_x0",  FL_LD,         3'd2, 0, 32'h0,     32'h2000,     32'hFFFFFFFC, 32'h0,        0,  32'h1FFC,     1, 0, 1, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("ld",     FL_LD,         3'd2, 0, 32'h0,     32'h2000,     32'h4,        32'h0,        9,  32'h2004,     1, 1, 1, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("st",     FL_ST,         3'd2, 0, 32'h0,     32'h10,       32'h8,        32'h0,        5,  32'h18,       1, 0, 0, 1, 0, 32'h0,     0, 1));
        vecs.push_back(mk("lui_x0", FL_UI,         3'd0, 0, 32'h0,     32'd4096,     32'h0,        32'h0,        0,  32'd4096,     1, 0, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("auipc",  FL_UI|FL_PC,   3'd0, 0, 32'h200,   32'h1000,     32'h0,        32'h0,        4,  32'h1200,     1, 1, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("nop",    8'h00,         3'd0, 0, 32'h0,     32'd1,        32'd1,        32'h0,        3,  32'h0,        0, 0, 0, 0, 0, 32'h0,     0, 1));
        vecs.push_back(mk("jal_end",FL_JUMP,       3'd0, 0, 32'h80,    32'h8,        32'h0,        32'h0,        1,  32'h84,       1, 1, 0, 0, 1, 32'h88,    1, 1));

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(8'h00, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.wb_en", wb_en, 0);
        check("rst.redirect", redirect, 0);
        check("rst.target", target, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst.in_ready", in_ready, 1);
        check("post_rst.out_valid", out_valid, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // last vector was a jump: once consumed, redirect must drop with out_valid
        @(negedge clk);
        check("drain.out_valid", out_valid, 0);
        check("drain.redirect", redirect, 0);

        // in_ready during a serial shift
        drive(FL_ALU, 3'd5, 1'b1, 32'h0, 32'hFFFFF000, 32'd4, 32'h0, 5'd5);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
`ifdef BARREL_SHIFT_EN
        check("srai_busy.in_ready", in_ready, 1);
        check("srai_busy.out_valid", out_valid, 1);
`else
        check("srai_busy.in_ready", in_ready, 0);
        check("srai_busy.out_valid", out_valid, 0);
`endif
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("srai_busy.result", result, 32'hFFFFFF00);
        @(negedge clk);

        // backpressure: lui held while a second op waits at the input
        drive(FL_UI, 3'd0, 1'b0, 32'h0, 32'd4096, 32'h0, 32'h0, 5'd1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 drive(FL_ALU|FL_REG, 3'd0, 1'b0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall.out_valid", out_valid, 1);
            check("stall.result", result, 32'd4096);
            check("stall.in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("release.out_valid", out_valid, 1);
        check("release.result", result, 32'd2);
        check("release.wb_dest", wb_dest, 2);
        @(negedge clk);
        check("release.drained", out_valid, 0);

        // reset while a 20-bit serial shift is in flight
        drive(FL_ALU, 3'd1, 1'b0, 32'h0, 32'd1, 32'd20, 32'h0, 5'd10);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst.out_valid", out_valid, 0);
        check("midrst.in_ready", in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst.in_ready_after", in_ready, 1);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst.dropped", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
